// File: rtl/piso_if.sv
// Load/ready word handshake plus serial stream outputs of the PISO serializer.
interface piso_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic             serial_out;
  logic             out_valid;
  logic             done;

  modport master (
    output load, din,
    input  ready, serial_out, out_valid, done
  );

  modport slave (
    input  load, din,
    output ready, serial_out, out_valid, done
  );
endinterface

// File: rtl/piso_serializer.sv
// MSB-first parallel-to-serial converter with a back-to-back load/ready handshake.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  piso_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
  localparam int unsigned LAST = WIDTH;
`else
  localparam int unsigned LAST = WIDTH - 1;
`endif

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_q, ser_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          state_d = SHIFT;
          sh_d    = bus.din;
          cnt_d   = '0;
`ifdef PISO_PARITY_EN
          par_d   = ^bus.din;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(LAST)) begin
          if (bus.load) begin
            sh_d  = bus.din;
            cnt_d = '0;
`ifdef PISO_PARITY_EN
            par_d = ^bus.din;
`endif
          end else begin
            state_d = IDLE;
            sh_d    = '0;
            cnt_d   = '0;
          end
        end else begin
          sh_d  = sh_q << 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    // Outputs are computed from next state so they sit in flops, not behind load/din.
    valid_d = (state_d == SHIFT);
    done_d  = valid_d && (cnt_d == CW'(LAST));
    ready_d = !valid_d || done_d;
    ser_d   = valid_d && sh_d[WIDTH-1];
`ifdef PISO_PARITY_EN
    if (cnt_d == CW'(WIDTH)) ser_d = valid_d && par_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.ready      = ready_q;
  assign bus.serial_out = ser_q;
  assign bus.out_valid  = valid_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed plus randomized bench for piso_serializer against a frame-level model.
module tb_piso_serializer;
  localparam int unsigned W = 4;
`ifdef PISO_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic clk = 1'b0;
  logic rst;
  bit   run = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [W-1:0] sipo;
  logic [W-1:0] w, n;
  logic         c;

  piso_if #(.WIDTH(W)) bus ();
  piso_serializer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always begin
    #5;
    if (run) clk = ~clk;
  end

  // Model of the downstream 4-bit SIPO: serial bit enters at the LSB, shifts toward MSB.
  always @(posedge clk or posedge rst) begin
    if (rst) sipo <= '0;
    else     sipo <= {sipo[W-2:0], bus.serial_out};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  // Expected k-th frame bit: data MSB first, then the parity bit if enabled.
  function automatic logic ebit(input logic [W-1:0] word, input int unsigned k);
    if (k < W) return word[W-1-k];
    return ^word;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, bus.out_valid, 1'b0);
    chk({tag, ".ser"},   bus.serial_out, 1'b0);
    chk({tag, ".done"},  bus.done, 1'b0);
    chk({tag, ".ready"}, bus.ready, 1'b1);
  endtask

  // Checks one frame whose first bit is already visible. busy: 0 quiet, 1 load all-ones, 2 random junk.
  task automatic frame(input logic [W-1:0] word, input logic chain, input logic [W-1:0] nxt,
                       input int unsigned busy, input string tag);
    for (int unsigned k = 0; k < FL; k++) begin
      chk($sformatf("%s.valid%0d", tag, k), bus.out_valid, 1'b1);
      chk($sformatf("%s.bit%0d", tag, k), bus.serial_out, ebit(word, k));
      chk($sformatf("%s.done%0d", tag, k), bus.done, k == FL - 1);
      chk($sformatf("%s.ready%0d", tag, k), bus.ready, k == FL - 1);
      if (k == FL - 1) begin
        bus.load = chain;
        bus.din  = chain ? nxt : W'($urandom);
      end else if (busy == 1) begin
        bus.load = 1'b1;
        bus.din  = '1;
      end else if (busy == 2) begin
        bus.load = 1'($urandom);
        bus.din  = W'($urandom);
      end else begin
        bus.load = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    rst      = 1'b1;
    bus.load = 1'b0;
    bus.din  = '0;
    #2;
    chk_idle("reset");
    #10;
    rst = 1'b0;

    // Single word
    bus.load = 1'b1; bus.din = 4'b1011;
    tick();
    frame(4'b1011, 1'b0, '0, 0, "single");
    chk_idle("single.end");

    // Back-to-back with no gap
    bus.load = 1'b1; bus.din = 4'b1011;
    tick();
    frame(4'b1011, 1'b1, 4'b0110, 0, "b2b0");
    frame(4'b0110, 1'b0, '0, 0, "b2b1");
    chk_idle("b2b.end");

    // Load while busy is ignored
    bus.load = 1'b1; bus.din = 4'b0001;
    tick();
    frame(4'b0001, 1'b0, '0, 1, "busy");
    chk_idle("busy.end");

    // Reset during the 3rd bit with the clock stalled
    bus.load = 1'b1; bus.din = 4'b1010;
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    chk("mid.pre_valid", bus.out_valid, 1'b1);
    chk("mid.pre_bit", bus.serial_out, 1'b1);
    run = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk_idle("mid.rst");
    #10;
    chk_idle("mid.hold");
    rst = 1'b0;
    #2;
    run = 1'b1;
    tick();
    chk_idle("mid.after");
    bus.load = 1'b1; bus.din = 4'b0101;
    tick();
    frame(4'b0101, 1'b0, '0, 0, "mid.next");
    chk_idle("mid.end");

    // Loopback into the SIPO
    bus.load = 1'b1; bus.din = 4'b1101;
    tick();
    bus.load = 1'b0;
    repeat (W) tick();
    total++;
    assert (sipo === 4'b1101) else begin
      bad++;
      $error("FAIL loopback observed=%b expected=%b", sipo, 4'b1101);
    end
    repeat (2) tick();
    chk_idle("loop.end");

`ifdef PISO_PARITY_EN
    bus.load = 1'b1; bus.din = 4'b1011;
    tick();
    frame(4'b1011, 1'b1, 4'b1001, 0, "par0");
    frame(4'b1001, 1'b0, '0, 0, "par1");
    chk_idle("par.end");
`endif

    // Randomized frames, chained or separated by random gaps
    w = W'($urandom);
    bus.load = 1'b1; bus.din = w;
    tick();
    for (int unsigned i = 0; i < 30; i++) begin
      c = 1'($urandom);
      n = W'($urandom);
      frame(w, c, n, 2, $sformatf("rnd%0d", i));
      if (!c) begin
        chk_idle($sformatf("rnd%0d.idle", i));
        repeat ($urandom_range(0, 2)) begin
          bus.load = 1'b0;
          tick();
          chk($sformatf("rnd%0d.gap", i), bus.out_valid, 1'b0);
        end
        bus.load = 1'b1; bus.din = n;
        tick();
      end
      w = n;
    end
    frame(w, 1'b0, '0, 0, "rnd.last");
    chk_idle("rnd.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
